// File: rtl/rtc_set_ctrl_pkg.sv
// Shared types and constants for the RTC time-setting front end.
// State encoding, BCD limits and cycle-count helpers.
package rtc_pkg;

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_SET_HOUR = 3'd1,
        S_SET_MIN  = 3'd2,
        S_SET_SEC  = 3'd3,
        S_COMMIT   = 3'd4
    } state_t;

    localparam logic [7:0] BCD_MAX_HOUR   = 8'h23;
    localparam logic [7:0] BCD_MAX_MINSEC = 8'h59;

    // Cycles per blink half-period; never below one cycle.
    function automatic int unsigned blink_half(int unsigned clk_hz,
                                               int unsigned blink_hz);
        int unsigned h;
        h = clk_hz / (2 * blink_hz);
        return (h == 0) ? 1 : h;
    endfunction

    // Cycles per one-second prescaler period.
    function automatic int unsigned sec_cycles(int unsigned clk_hz);
        return (clk_hz == 0) ? 1 : clk_hz;
    endfunction

    // Valid BCD byte no greater than the field maximum.
    function automatic logic bcd_ok(logic [7:0] v, logic [7:0] max);
        return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9) && (v <= max);
    endfunction

    // Replace an out-of-range field with 00.
    function automatic logic [7:0] bcd_clean(logic [7:0] v, logic [7:0] max);
        return bcd_ok(v, max) ? v : 8'h00;
    endfunction

endpackage

// File: rtl/rtc_set_ctrl_if.sv
// Key, RTC read, display and commit signals of the time-setting block.
// master drives keys and RTC readings; slave is the controller.
interface rtc_set_ctrl_if;

    logic       key_mode;
    logic       key_up;
    logic       key_down;
    logic [7:0] read_second;
    logic [7:0] read_minute;
    logic [7:0] read_hour;
    logic [7:0] read_date;
    logic [7:0] read_month;
    logic [7:0] read_week;
    logic [7:0] read_year;
    logic [7:0] disp_hour;
    logic [7:0] disp_minute;
    logic [7:0] disp_second;
    logic [2:0] blink_mask;
    logic       set_active;
    logic       write_time_req;
    logic [7:0] write_second;
    logic [7:0] write_minute;
    logic [7:0] write_hour;
    logic [7:0] write_date;
    logic [7:0] write_month;
    logic [7:0] write_week;
    logic [7:0] write_year;

    modport master (
        output key_mode, key_up, key_down,
        output read_second, read_minute, read_hour,
        output read_date, read_month, read_week, read_year,
        input  disp_hour, disp_minute, disp_second,
        input  blink_mask, set_active, write_time_req,
        input  write_second, write_minute, write_hour,
        input  write_date, write_month, write_week, write_year
    );

    modport slave (
        input  key_mode, key_up, key_down,
        input  read_second, read_minute, read_hour,
        input  read_date, read_month, read_week, read_year,
        output disp_hour, disp_minute, disp_second,
        output blink_mask, set_active, write_time_req,
        output write_second, write_minute, write_hour,
        output write_date, write_month, write_week, write_year
    );

endinterface

// File: rtl/rtc_set_ctrl_bcd_step.sv
// Single-step wrapping BCD up/down counter, purely combinational.
// Simultaneous up and down leave the value unchanged.
module bcd_step (
    input  logic [7:0] val,
    input  logic [7:0] max,
    input  logic       up,
    input  logic       down,
    output logic [7:0] nxt
);

    // wrap at max/00, carry or borrow between BCD digits
    always_comb begin
        nxt = val;
        if (up && !down) begin
            if (val >= max)
                nxt = 8'h00;
            else if (val[3:0] == 4'h9)
                nxt = {val[7:4] + 4'h1, 4'h0};
            else
                nxt = val + 8'h01;
        end else if (down && !up) begin
            if (val == 8'h00)
                nxt = max;
            else if (val[3:0] == 4'h0)
                nxt = {val[7:4] - 4'h1, 4'h9};
            else
                nxt = val - 8'h01;
        end
    end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Time-setting front end for the DS1302 RTC processor.
// Optional idle timeout of set mode: define RTC_SET_TIMEOUT_EN.
import rtc_pkg::*;

module rtc_set_ctrl #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BLINK_HZ  = 2,
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic          clk,
    input  logic          rst,
    rtc_set_ctrl_if.slave bus
);

    localparam int unsigned HALF  = blink_half(CLK_HZ, BLINK_HZ);
    localparam int unsigned BLK_W = $clog2(HALF + 1);

    state_t     state, state_nxt;
    logic [7:0] ed_hour, ed_min, ed_sec;
    logic [7:0] cap_date, cap_month, cap_week, cap_year;
    logic [7:0] nxt_hour, nxt_min, nxt_sec;
    logic       any_key;
    logic       in_set;
    logic       timeout;
    logic       phase;
    logic [BLK_W-1:0] blk_cnt;
    logic       unused_bits;

    assign unused_bits = ^{bus.read_hour[7:6], bus.read_second[7]};
    assign any_key = bus.key_mode | bus.key_up | bus.key_down;
    assign in_set  = (state == S_SET_HOUR) || (state == S_SET_MIN) ||
                     (state == S_SET_SEC);

    bcd_step u_step_hour (
        .val  (ed_hour),
        .max  (BCD_MAX_HOUR),
        .up   (bus.key_up),
        .down (bus.key_down),
        .nxt  (nxt_hour)
    );

    bcd_step u_step_min (
        .val  (ed_min),
        .max  (BCD_MAX_MINSEC),
        .up   (bus.key_up),
        .down (bus.key_down),
        .nxt  (nxt_min)
    );

    bcd_step u_step_sec (
        .val  (ed_sec),
        .max  (BCD_MAX_MINSEC),
        .up   (bus.key_up),
        .down (bus.key_down),
        .nxt  (nxt_sec)
    );

`ifdef RTC_SET_TIMEOUT_EN
    localparam int unsigned SEC_N  = sec_cycles(CLK_HZ);
    localparam int unsigned SEC_W  = $clog2(SEC_N + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);

    logic [SEC_W-1:0]  pre_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              sec_tick;

    assign sec_tick = (pre_cnt == SEC_W'(SEC_N - 1));
    assign timeout  = (TIMEOUT_S != 0) && sec_tick &&
                      (idle_cnt == IDLE_W'(TIMEOUT_S - 1));

    // idle-second counting while editing; any key restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            idle_cnt <= '0;
        end else if (!in_set || any_key) begin
            pre_cnt  <= '0;
            idle_cnt <= '0;
        end else if (sec_tick) begin
            pre_cnt  <= '0;
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            pre_cnt  <= pre_cnt + 1'b1;
        end
    end
`else
    // set mode never times out in this build
    assign timeout = 1'b0 && (TIMEOUT_S != 0);
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    // next state and mode-derived outputs; mode key beats timeout
    always_comb begin
        state_nxt          = state;
        bus.set_active     = 1'b0;
        bus.write_time_req = 1'b0;
        bus.blink_mask     = 3'b000;
        unique case (state)
            S_RUN: begin
                if (bus.key_mode)
                    state_nxt = S_SET_HOUR;
            end
            S_SET_HOUR: begin
                bus.set_active = 1'b1;
                bus.blink_mask = {phase, 2'b00};
                if (bus.key_mode)
                    state_nxt = S_SET_MIN;
                else if (timeout)
                    state_nxt = S_RUN;
            end
            S_SET_MIN: begin
                bus.set_active = 1'b1;
                bus.blink_mask = {1'b0, phase, 1'b0};
                if (bus.key_mode)
                    state_nxt = S_SET_SEC;
                else if (timeout)
                    state_nxt = S_RUN;
            end
            S_SET_SEC: begin
                bus.set_active = 1'b1;
                bus.blink_mask = {2'b00, phase};
                if (bus.key_mode)
                    state_nxt = S_COMMIT;
                else if (timeout)
                    state_nxt = S_RUN;
            end
            S_COMMIT: begin
                bus.set_active     = 1'b1;
                bus.write_time_req = 1'b1;
                state_nxt          = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // capture on entry, then step the field being edited
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ed_hour   <= '0;
            ed_min    <= '0;
            ed_sec    <= '0;
            cap_date  <= '0;
            cap_month <= '0;
            cap_week  <= '0;
            cap_year  <= '0;
        end else if (state == S_RUN) begin
            if (bus.key_mode) begin
                ed_hour   <= bcd_clean({2'b00, bus.read_hour[5:0]},
                                       BCD_MAX_HOUR);
                ed_min    <= bcd_clean({1'b0, bus.read_minute[6:0]},
                                       BCD_MAX_MINSEC);
                ed_sec    <= bcd_clean({1'b0, bus.read_second[6:0]},
                                       BCD_MAX_MINSEC);
                cap_date  <= bus.read_date;
                cap_month <= bus.read_month;
                cap_week  <= bus.read_week;
                cap_year  <= bus.read_year;
            end
        end else if (!bus.key_mode) begin
            if (state == S_SET_HOUR)
                ed_hour <= nxt_hour;
            if (state == S_SET_MIN)
                ed_min <= nxt_min;
            if (state == S_SET_SEC)
                ed_sec <= nxt_sec;
        end
    end

    // commit values, loaded as the commit state is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.write_second <= '0;
            bus.write_minute <= '0;
            bus.write_hour   <= '0;
            bus.write_date   <= '0;
            bus.write_month  <= '0;
            bus.write_week   <= '0;
            bus.write_year   <= '0;
        end else if (state == S_SET_SEC && bus.key_mode) begin
            bus.write_second <= {1'b0, ed_sec[6:0]};
            bus.write_minute <= ed_min;
            bus.write_hour   <= {2'b00, ed_hour[5:0]};
            bus.write_date   <= cap_date;
            bus.write_month  <= cap_month;
            bus.write_week   <= cap_week;
            bus.write_year   <= cap_year;
        end
    end

    // display register: live time when running, edit values otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.disp_hour   <= '0;
            bus.disp_minute <= '0;
            bus.disp_second <= '0;
        end else if (state == S_RUN) begin
            bus.disp_hour   <= {2'b00, bus.read_hour[5:0]};
            bus.disp_minute <= bus.read_minute;
            bus.disp_second <= {1'b0, bus.read_second[6:0]};
        end else begin
            bus.disp_hour   <= ed_hour;
            bus.disp_minute <= ed_min;
            bus.disp_second <= ed_sec;
        end
    end

    // blink phase; keys restart it visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
        end else if (!in_set || any_key) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
        end else if (blk_cnt == BLK_W'(HALF - 1)) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Directed self-checking bench for rtc_set_ctrl.
// Small clock rate so blink and timeout periods are a few cycles.
module tb_rtc_set_ctrl;

    import rtc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   req_cnt = 0;
    int   req_base;

    rtc_set_ctrl_if bus ();

    rtc_set_ctrl #(
        .CLK_HZ    (20),
        .BLINK_HZ  (2),
        .TIMEOUT_S (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // count cycles with the commit pulse high
    always @(posedge clk)
        if (!rst && bus.write_time_req === 1'b1)
            req_cnt++;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++)
            @(negedge clk);
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        @(negedge clk);
        bus.key_mode = m;
        bus.key_up   = u;
        bus.key_down = d;
        @(negedge clk);
        bus.key_mode = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
    endtask

    task automatic set_read(input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
        bus.read_hour   = h;
        bus.read_minute = m;
        bus.read_second = s;
    endtask

    initial begin
        bus.key_mode   = 1'b0;
        bus.key_up     = 1'b0;
        bus.key_down   = 1'b0;
        set_read(8'h00, 8'h00, 8'h00);
        bus.read_date  = 8'h00;
        bus.read_month = 8'h00;
        bus.read_week  = 8'h00;
        bus.read_year  = 8'h00;

        // reset state
        step(3);
        chk("rst_disp_hour", bus.disp_hour, 8'h00);
        chk("rst_disp_sec", bus.disp_second, 8'h00);
        chk("rst_set_active", {7'd0, bus.set_active}, 8'h00);
        chk("rst_req", {7'd0, bus.write_time_req}, 8'h00);
        chk("rst_blink", {5'd0, bus.blink_mask}, 8'h00);
        chk("rst_wr_sec", bus.write_second, 8'h00);
        rst = 1'b0;

        // live display
        set_read(8'h12, 8'h34, 8'h56);
        step();
        chk("live_hour", bus.disp_hour, 8'h12);
        chk("live_min", bus.disp_minute, 8'h34);
        chk("live_sec", bus.disp_second, 8'h56);
        chk("live_blink", {5'd0, bus.blink_mask}, 8'h00);

        // wrap: hour 23 up -> 00, min 00 down... from 59 down is 58
        set_read(8'h23, 8'h00, 8'h58);
        step();
        press(1'b1, 1'b0, 1'b0);
        chk("enter_set_active", {7'd0, bus.set_active}, 8'h01);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        step();
        chk("wrap_hour", bus.disp_hour, 8'h00);
        chk("wrap_min", bus.disp_minute, 8'h59);
        chk("wrap_sec", bus.disp_second, 8'h58);
        chk("blink_vis", {5'd0, bus.blink_mask}, 8'h00);
        step(3);
        chk("blink_still_vis", {5'd0, bus.blink_mask}, 8'h00);
        step();
        chk("blink_min_on", {5'd0, bus.blink_mask}, 8'h02);

        // up+down together: no change, phase restarts
        press(1'b0, 1'b1, 1'b1);
        step();
        chk("updown_min", bus.disp_minute, 8'h59);
        chk("updown_blink", {5'd0, bus.blink_mask}, 8'h00);

        // mode+up together: field advances, value unchanged
        press(1'b1, 1'b1, 1'b0);
        step();
        chk("modeup_min", bus.disp_minute, 8'h59);
        chk("modeup_sec", bus.disp_second, 8'h58);
        step(4);
        chk("blink_sec_on", {5'd0, bus.blink_mask}, 8'h01);

        // commit edited 00:59:58
        req_base = req_cnt;
        press(1'b1, 1'b0, 1'b0);
        step(2);
        chk("c1_req_count", 8'(req_cnt - req_base), 8'h01);
        chk("c1_wr_hour", bus.write_hour, 8'h00);
        chk("c1_wr_min", bus.write_minute, 8'h59);
        chk("c1_wr_sec", bus.write_second, 8'h58);
        chk("c1_set_active", {7'd0, bus.set_active}, 8'h00);

        // commit with CH set in read_second
        set_read(8'h08, 8'h15, 8'hD6);
        bus.read_date  = 8'h21;
        bus.read_month = 8'h07;
        bus.read_week  = 8'h03;
        bus.read_year  = 8'h24;
        step();
        chk("ch_live_sec", bus.disp_second, 8'h56);
        req_base = req_cnt;
        press(1'b1, 1'b0, 1'b0);
        bus.read_date = 8'h30;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        step(2);
        chk("c2_req_count", 8'(req_cnt - req_base), 8'h01);
        chk("c2_wr_sec", bus.write_second, 8'h56);
        chk("c2_wr_min", bus.write_minute, 8'h15);
        chk("c2_wr_hour", bus.write_hour, 8'h08);
        chk("c2_wr_date", bus.write_date, 8'h21);
        chk("c2_wr_month", bus.write_month, 8'h07);
        chk("c2_wr_week", bus.write_week, 8'h03);
        chk("c2_wr_year", bus.write_year, 8'h24);

        // sanitise: hour 3F loads as 00
        bus.read_hour = 8'h3F;
        step();
        press(1'b1, 1'b0, 1'b0);
        step();
        chk("san_hour", bus.disp_hour, 8'h00);
        chk("san_min", bus.disp_minute, 8'h15);
        bus.read_minute = 8'h42;
        step();
        chk("frozen_min", bus.disp_minute, 8'h15);

        // idle in set mode
        req_base = req_cnt;
        step(25);
        chk("idle_short_active", {7'd0, bus.set_active}, 8'h01);
        step(20);
`ifdef RTC_SET_TIMEOUT_EN
        chk("to_set_active", {7'd0, bus.set_active}, 8'h00);
        chk("to_req_count", 8'(req_cnt - req_base), 8'h00);
        chk("to_wr_sec", bus.write_second, 8'h56);
        press(1'b1, 1'b0, 1'b0);
`else
        chk("noto_set_active", {7'd0, bus.set_active}, 8'h01);
`endif

        // reset mid-edit
        press(1'b0, 1'b1, 1'b0);
        step();
        chk("mid_hour_up", bus.disp_hour, 8'h01);
        req_base = req_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("mr_set_active", {7'd0, bus.set_active}, 8'h00);
        chk("mr_req_count", 8'(req_cnt - req_base), 8'h00);
        chk("mr_wr_sec", bus.write_second, 8'h00);
        chk("mr_wr_hour", bus.write_hour, 8'h00);
        chk("mr_wr_date", bus.write_date, 8'h00);
        chk("mr_disp_hour", bus.disp_hour, 8'h3F);
        step(2);
        chk("mr_no_late_req", 8'(req_cnt - req_base), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
